// File: rtl/phase_sequencer.sv
// phase_sequencer: intersection phase controller producing light step pulses and pedestrian levels
module phase_sequencer #(
    parameter int TICKS_PER_MS = 10,
    parameter int MAIN_MIN_MS  = 20000,
    parameter int SIDE_MS      = 15000,
    parameter int YELLOW_MS    = 3000,
    parameter int ALLRED_MS    = 1000,
    parameter int WALK_MS      = 10000,
    parameter int CLEAR_MS     = 5000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       sensor_nn,
    input  logic       sensor_ns,
    input  logic       btn_nn,
    input  logic       btn_ns,
    input  logic       btn_th,
    output logic       set_all,
    output logic       change_main,
    output logic       change_side,
    output logic       ped_walk,
    output logic       ped_clear,
    output logic [3:0] phase,
    output logic       side_req_o,
    output logic       ped_req_o
);
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    typedef enum logic [3:0] {
        INIT, AR_START, MAIN_GREEN, MAIN_YELLOW, AR_MAIN,
        SIDE_GREEN, SIDE_YELLOW, AR_SIDE, PED_WALK, PED_CLEAR
    } state_t;
    state_t state, state_nxt;
    logic [4:0] sync1, sync2;
    logic [2:0] btn_prev;
    logic [PW-1:0] prescaler;
    logic [17:0] elapsed_ms, dur_ms;
    logic min_done, min_ok, ms_tick, up, enter, sensed, btn_rise;
    logic set_all_nxt, change_main_nxt, change_side_nxt, side_req_nxt, ped_req_nxt;

    assign phase    = state;
    assign sensed   = sync2[4] | sync2[3];
    assign btn_rise = |(sync2[2:0] & ~btn_prev);
    assign ms_tick  = en && (prescaler == PW'(TICKS_PER_MS - 1));
    assign min_ok   = min_done || (elapsed_ms >= 18'(MAIN_MIN_MS));
    assign up       = ms_tick && (elapsed_ms + 18'd1 >= dur_ms);
    assign enter    = state_nxt != state;

    // Two-flop synchronisers for the async sensors/buttons, plus a history flop for button edges
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
        end else begin
            sync1    <= {sensor_nn, sensor_ns, btn_nn, btn_ns, btn_th};
            sync2    <= sync1;
            btn_prev <= sync2[2:0];
        end
    end

    // State, phase timer, demand latches and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            prescaler   <= '0;
            elapsed_ms  <= '0;
            min_done    <= 1'b0;
            side_req_o  <= 1'b0;
            ped_req_o   <= 1'b0;
            set_all     <= 1'b0;
            change_main <= 1'b0;
            change_side <= 1'b0;
            ped_walk    <= 1'b0;
            ped_clear   <= 1'b0;
        end else begin
            state       <= state_nxt;
            prescaler   <= (enter || ms_tick) ? '0 : en ? prescaler + PW'(1) : prescaler;
            elapsed_ms  <= enter ? '0 : ms_tick ? elapsed_ms + 18'd1 : elapsed_ms;
            min_done    <= enter ? 1'b0 : min_ok;
            side_req_o  <= side_req_nxt;
            ped_req_o   <= ped_req_nxt;
            set_all     <= set_all_nxt;
            change_main <= change_main_nxt;
            change_side <= change_side_nxt;
            ped_walk    <= state_nxt == PED_WALK;
            ped_clear   <= state_nxt == PED_CLEAR;
        end
    end

    // Next-state: timed phases advance when their duration expires; main green waits for demand
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:        if (en) state_nxt = AR_START;
            AR_START:    if (up) state_nxt = MAIN_GREEN;
            MAIN_GREEN:  if (en && min_ok && (side_req_o || ped_req_o)) state_nxt = MAIN_YELLOW;
            MAIN_YELLOW: if (up) state_nxt = AR_MAIN;
            AR_MAIN:     if (up) state_nxt = side_req_o ? SIDE_GREEN : PED_WALK;
            SIDE_GREEN:  if (up) state_nxt = SIDE_YELLOW;
            SIDE_YELLOW: if (up) state_nxt = AR_SIDE;
            AR_SIDE:     if (up) state_nxt = ped_req_o ? PED_WALK : MAIN_GREEN;
            PED_WALK:    if (up) state_nxt = PED_CLEAR;
            PED_CLEAR:   if (up) state_nxt = MAIN_GREEN;
            default:     state_nxt = INIT;
        endcase
    end

    // Outputs: phase durations, pulses keyed on the destination state, and demand latching (clear wins)
    always_comb begin
        dur_ms = (state == AR_START || state == AR_MAIN || state == AR_SIDE) ? 18'(ALLRED_MS) :
                 (state == MAIN_YELLOW || state == SIDE_YELLOW) ? 18'(YELLOW_MS) :
                 (state == SIDE_GREEN) ? 18'(SIDE_MS) :
                 (state == PED_WALK) ? 18'(WALK_MS) : 18'(CLEAR_MS);
        set_all_nxt     = enter && state_nxt == AR_START;
        change_main_nxt = enter && (state_nxt inside {MAIN_GREEN, MAIN_YELLOW, AR_MAIN});
        change_side_nxt = enter && (state_nxt inside {SIDE_GREEN, SIDE_YELLOW, AR_SIDE});
        side_req_nxt    = (enter && state_nxt == SIDE_GREEN) ? 1'b0 :
                          (sensed && !(state inside {SIDE_GREEN, SIDE_YELLOW})) ? 1'b1 : side_req_o;
        ped_req_nxt     = (enter && state_nxt == PED_WALK) ? 1'b0 :
                          (btn_rise && state != PED_WALK) ? 1'b1 : ped_req_o;
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: table-driven phase walk of phase_sequencer with a per-cycle expectation queue
module tb_phase_sequencer;
    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic sensor_nn = 1'b0, sensor_ns = 1'b0, btn_nn = 1'b0, btn_ns = 1'b0, btn_th = 1'b0;
    logic set_all, change_main, change_side, ped_walk, ped_clear, side_req_o, ped_req_o;
    logic [3:0] phase;

    phase_sequencer #(
        .TICKS_PER_MS(2), .MAIN_MIN_MS(4), .SIDE_MS(5), .YELLOW_MS(2),
        .ALLRED_MS(1), .WALK_MS(3), .CLEAR_MS(2)
    ) dut (
        .CLK(CLK), .reset(reset), .en(en),
        .sensor_nn(sensor_nn), .sensor_ns(sensor_ns),
        .btn_nn(btn_nn), .btn_ns(btn_ns), .btn_th(btn_th),
        .set_all(set_all), .change_main(change_main), .change_side(change_side),
        .ped_walk(ped_walk), .ped_clear(ped_clear), .phase(phase),
        .side_req_o(side_req_o), .ped_req_o(ped_req_o)
    );

    always #5 CLK = ~CLK;

    localparam logic [4:0] NO = 5'b00000, NN = 5'b10000, NS = 5'b01000;
    localparam logic [4:0] BNN = 5'b00100, BNS = 5'b00010, BTH = 5'b00001;
    localparam logic [2:0] P0 = 3'b000, PS = 3'b100, PM = 3'b010, PC = 3'b001;

    typedef struct {
        bit         rst;
        bit         en;
        logic [4:0] in;
        int         n;
        logic [3:0] ph;
        logic [2:0] pul;
        bit         walk;
        bit         clr;
        logic [1:0] req;
    } vec_t;

    vec_t tbl[$];
    logic [10:0] exp_q[$];
    int tag_q[$];
    int vectors = 0;
    int miscompares = 0;
    int split;

    task automatic add(input bit rst, input bit e, input logic [4:0] in, input int n,
                       input logic [3:0] ph, input logic [2:0] pul, input bit w, input bit c,
                       input logic [1:0] req);
        vec_t r;
        r.rst = rst; r.en = e; r.in = in; r.n = n; r.ph = ph;
        r.pul = pul; r.walk = w; r.clr = c; r.req = req;
        tbl.push_back(r);
    endtask

    task automatic check_now();
        logic [10:0] got, want;
        int id;
        got  = {phase, set_all, change_main, change_side, ped_walk, ped_clear, side_req_o, ped_req_o};
        want = exp_q.pop_front();
        id   = tag_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rec%0d phase/set/cm/cs/walk/clr/sreq/preq: got %b want %b", id, got, want);
        end
    endtask

    task automatic run(input int from, input int to);
        for (int i = from; i < to; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                reset = tbl[i].rst;
                en = tbl[i].en;
                {sensor_nn, sensor_ns, btn_nn, btn_ns, btn_th} = tbl[i].in;
                exp_q.push_back({tbl[i].ph, (k == 0) ? tbl[i].pul : P0, tbl[i].walk, tbl[i].clr, tbl[i].req});
                tag_q.push_back(i);
                @(posedge CLK);
                @(negedge CLK);
                check_now();
            end
        end
    endtask

    initial begin
        // reset, idle in INIT without en, start-up all-red then long rest in main green
        add(0, 0, NO, 3, 4'd0, P0, 0, 0, 2'b00);
        add(1, 0, NO, 3, 4'd0, P0, 0, 0, 2'b00);
        add(1, 1, NO, 2, 4'd1, PS, 0, 0, 2'b00);
        add(1, 1, NO, 1001, 4'd2, PM, 0, 0, 2'b00);
        // one-cycle side sensor: full side service
        add(1, 1, NN, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b10);
        add(1, 1, NO, 4, 4'd3, PM, 0, 0, 2'b10);
        add(1, 1, NO, 2, 4'd4, PM, 0, 0, 2'b10);
        add(1, 1, NO, 10, 4'd5, PC, 0, 0, 2'b00);
        add(1, 1, NO, 4, 4'd6, PC, 0, 0, 2'b00);
        add(1, 1, NO, 2, 4'd7, PC, 0, 0, 2'b00);
        add(1, 1, NO, 12, 4'd2, PM, 0, 0, 2'b00);
        // main-street button only: pedestrian phases straight after main all-red
        add(1, 1, BTH, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b01);
        add(1, 1, NO, 4, 4'd3, PM, 0, 0, 2'b01);
        add(1, 1, NO, 2, 4'd4, PM, 0, 0, 2'b01);
        add(1, 1, NO, 6, 4'd8, P0, 1, 0, 2'b00);
        add(1, 1, NO, 4, 4'd9, P0, 0, 1, 2'b00);
        add(1, 1, NO, 2, 4'd2, PM, 0, 0, 2'b00);
        // side and pedestrian demand early in main green: min green enforced, side first then walk
        add(1, 1, NS | BNN, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 5, 4'd2, P0, 0, 0, 2'b11);
        add(1, 1, NO, 4, 4'd3, PM, 0, 0, 2'b11);
        add(1, 1, NO, 2, 4'd4, PM, 0, 0, 2'b11);
        add(1, 1, NO, 10, 4'd5, PC, 0, 0, 2'b01);
        add(1, 1, NO, 4, 4'd6, PC, 0, 0, 2'b01);
        add(1, 1, NO, 2, 4'd7, PC, 0, 0, 2'b01);
        add(1, 1, NO, 6, 4'd8, P0, 1, 0, 2'b00);
        add(1, 1, NO, 4, 4'd9, P0, 0, 1, 2'b00);
        add(1, 1, NO, 2, 4'd2, PM, 0, 0, 2'b00);
        // freeze for 7 cycles inside side green: 17 cycles total
        add(1, 1, NN, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 5, 4'd2, P0, 0, 0, 2'b10);
        add(1, 1, NO, 4, 4'd3, PM, 0, 0, 2'b10);
        add(1, 1, NO, 2, 4'd4, PM, 0, 0, 2'b10);
        add(1, 1, NO, 4, 4'd5, PC, 0, 0, 2'b00);
        add(1, 0, NO, 7, 4'd5, P0, 0, 0, 2'b00);
        add(1, 1, NO, 6, 4'd5, P0, 0, 0, 2'b00);
        add(1, 1, NO, 4, 4'd6, PC, 0, 0, 2'b00);
        add(1, 1, NO, 2, 4'd7, PC, 0, 0, 2'b00);
        add(1, 1, NO, 2, 4'd2, PM, 0, 0, 2'b00);
        // side-street button, then side demand latched during walk
        add(1, 1, BNS, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 1, 4'd2, P0, 0, 0, 2'b00);
        add(1, 1, NO, 5, 4'd2, P0, 0, 0, 2'b01);
        add(1, 1, NO, 4, 4'd3, PM, 0, 0, 2'b01);
        add(1, 1, NO, 2, 4'd4, PM, 0, 0, 2'b01);
        add(1, 1, NO, 2, 4'd8, P0, 1, 0, 2'b00);
        add(1, 1, NN, 1, 4'd8, P0, 1, 0, 2'b00);
        add(1, 1, NO, 1, 4'd8, P0, 1, 0, 2'b00);
        add(1, 1, NO, 1, 4'd8, P0, 1, 0, 2'b10);
        split = tbl.size();
        // after async reset mid-walk: held in reset, then set_all replay
        add(0, 1, NO, 2, 4'd0, P0, 0, 0, 2'b00);
        add(1, 1, NO, 2, 4'd1, PS, 0, 0, 2'b00);
        add(1, 1, NO, 3, 4'd2, PM, 0, 0, 2'b00);

        @(negedge CLK);
        run(0, split);
        // asynchronous reset: outputs and requests drop before any clock edge
        reset = 1'b0;
        exp_q.push_back(11'b0);
        tag_q.push_back(split);
        #1;
        check_now();
        @(negedge CLK);
        run(split, tbl.size());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
